icache_resp: RTL and testbench
==============================

Name: icache_resp

Overview:
- Instruction-cache end of the fetch/I-cache interface.
- Accepts fetch requests, returns one instruction per accepted request, and refills misses from a word-wide instruction memory port.
- Direct-mapped, read-only, blocking (one outstanding miss). It sits between the fetch stage and the instruction memory/bus.

Parameters:
- ADDR, 32, byte address width.
- INST, 32, instruction/word width.
- LINE_WORDS, 4, words per line (power of 2, >=2).
- SETS, 64, number of lines (power of 2).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- fetch_req  in  1  fetch request, valid this cycle.
- fetch_pc  in  ADDR  request byte address; bits [1:0] ignored.
- ic_busy  out  1  request not accepted this cycle.
- inst_valid  out  1  inst holds the response for the last accepted request.
- inst  out  INST  returned instruction.
- flush  in  1  invalidate entire cache.
- mem_req  out  1  memory read request.
- mem_addr  out  ADDR  word-aligned memory read address.
- mem_ack  in  1  memory returns mem_rdata this cycle.
- mem_rdata  in  INST  memory read data.

Behaviour:
- Address split, LSB up:
  - 2 byte bits, then log2(LINE_WORDS) word-offset bits, then log2(SETS) index bits.
  - The tag is the remainder.
- Storage per set: valid bit, tag, LINE_WORDS data words.
- Reset (async, active-high): all valid bits = 0, FSM = IDLE. Outputs: ic_busy=0, inst_valid=0, inst=0, mem_req=0, mem_addr=0.
- Acceptance: a request is accepted when fetch_req=1 and ic_busy=0 at a clk edge.
- Hit: inst_valid=1 and inst=word in the following cycle (1-cycle latency). Back-to-back hits sustain 1 instruction/cycle.
- inst_valid is a 1-cycle pulse per accepted request. inst holds its last value otherwise.
- Miss: in the cycle after acceptance, ic_busy=1 and the FSM enters REFILL. The missed pc, index and tag are latched.
- FSM states:
  - IDLE: serve hits. On a miss, go to REFILL with word counter = 0.
  - REFILL:
    - mem_req=1; mem_addr = line base + counter*(INST/8).
    - Words are fetched in ascending order starting at offset 0 (no critical-word-first).
    - Each mem_ack writes mem_rdata into the line and increments the counter.
    - mem_req stays high across acks; each ack consumes one word.
    - On the ack of the last word: set valid, write the tag, go to RESP.
  - RESP:
    - inst_valid=1, inst = latched word (taken from the refilled line or bypassed from mem_rdata).
    - ic_busy=0 in this cycle, so a new request may be accepted. The FSM returns to IDLE and serves that request as a normal lookup.
- ic_busy=1 throughout REFILL. It is 0 in IDLE and RESP unless flush=1.
- Flush:
  - flush=1 clears all valid bits at the edge and forces ic_busy=1 that cycle (no acceptance).
  - In REFILL: the refill is aborted, the line stays invalid, the FSM goes to IDLE and no inst_valid is issued. mem_req drops the next cycle; an ack arriving in the flush cycle is discarded.
  - A flush arriving in the same cycle as a hit response does not suppress that response.
- Wrap-around: the word counter is log2(LINE_WORDS) bits and wraps only on the final word. The top line of the address space refills without address overflow (mem_addr computed modulo 2^ADDR).
- Simultaneous events:
  - A request arriving while ic_busy=1 is ignored; fetch must hold or retry.
  - A miss replacing a valid line overwrites it; there is no dirty state.
- Reset mid-refill: the FSM returns to IDLE, all lines become invalid and mem_req=0 immediately (async).

Test Plan:
- Reset, then memory preloaded with word[a] = a, fetch_pc=0x100 -> mem_req reads 0x100,0x104,0x108,0x10C in order; then inst_valid=1 with inst=0x100, ic_busy=0.
- After that fill, fetch_pc=0x104,0x108,0x10C on consecutive cycles -> no mem_req; inst=0x104,0x108,0x10C on the 3 following cycles.
- Conflict: with SETS=64 and LINE_WORDS=4, 0x100 and 0x500 share an index. Fetch 0x500 after 0x100 -> refill; then 0x100 misses again (mem_req reasserted).
- mem_ack withheld for 5 cycles per word -> ic_busy stays 1 for the whole refill; requests presented then are dropped; exactly one inst_valid pulse.
- flush asserted after the 2nd ack of a refill -> no inst_valid; mem_req low the next cycle; a re-fetch of the same pc does a full 4-word refill.
- reset asserted mid-refill then released; fetch of a previously cached pc -> treated as a miss; outputs are 0 while reset is held.

Source files
------------

// File: rtl/icache_resp_if.sv
// icache_resp_if: fetch-side and memory-side signals of the instruction cache
interface icache_resp_if #(parameter int ADDR = 32, parameter int INST = 32);
  logic            fetch_req;
  logic [ADDR-1:0] fetch_pc;
  logic            ic_busy;
  logic            inst_valid;
  logic [INST-1:0] inst;
  logic            flush;
  logic            mem_req;
  logic [ADDR-1:0] mem_addr;
  logic            mem_ack;
  logic [INST-1:0] mem_rdata;
  modport slave (
    input  fetch_req, fetch_pc, flush, mem_ack, mem_rdata,
    output ic_busy, inst_valid, inst, mem_req, mem_addr
  );
  modport master (
    output fetch_req, fetch_pc, flush, mem_ack, mem_rdata,
    input  ic_busy, inst_valid, inst, mem_req, mem_addr
  );
endinterface

// File: rtl/icache_resp.sv
// icache_resp: direct-mapped blocking read-only I-cache, line refill from a word-wide memory port
module icache_resp #(
  parameter int ADDR       = 32,
  parameter int INST       = 32,
  parameter int LINE_WORDS = 4,
  parameter int SETS       = 64
) (
  input logic          clk,
  input logic          reset,
  icache_resp_if.slave bus
);
  localparam int OB = $clog2(LINE_WORDS);
  localparam int IB = $clog2(SETS);
  localparam int TW = ADDR - 2 - OB - IB;
  typedef enum logic [1:0] {IDLE, REFILL, RESP} state_t;
  state_t          r_state;
  logic [SETS-1:0] r_valid;
  logic [TW-1:0]   r_tag [SETS];
  logic [INST-1:0] r_data [SETS*LINE_WORDS];
  logic [ADDR-1:0] r_pc;
  logic [OB-1:0]   r_cnt;
  logic [INST-1:0] r_word;
  logic [INST-1:0] r_inst;
  logic            r_inst_valid;
  logic [IB-1:0]   w_idx, w_ridx;
  logic [OB-1:0]   w_off, w_roff;
  logic [TW-1:0]   w_tag, w_rtag;
  logic [ADDR-1:0] w_base;
  logic            w_hit, w_last, w_fill, w_unused;
  assign w_idx    = bus.fetch_pc[2+OB +: IB];
  assign w_off    = bus.fetch_pc[2 +: OB];
  assign w_tag    = bus.fetch_pc[ADDR-1 -: TW];
  assign w_ridx   = r_pc[2+OB +: IB];
  assign w_roff   = r_pc[2 +: OB];
  assign w_rtag   = r_pc[ADDR-1 -: TW];
  assign w_base   = {r_pc[ADDR-1:2+OB], {(OB+2){1'b0}}};
  assign w_hit    = r_valid[w_idx] && r_tag[w_idx] == w_tag;
  assign w_last   = &r_cnt;
  assign w_fill   = r_state == REFILL && bus.mem_ack && !bus.flush;
  assign w_unused = &{1'b0, bus.fetch_pc[1:0], r_pc[1:0]};
  assign bus.ic_busy    = r_state == REFILL || bus.flush;
  assign bus.inst_valid = r_inst_valid;
  assign bus.inst       = r_inst;
  assign bus.mem_req    = r_state == REFILL;
  assign bus.mem_addr   = r_state == REFILL ? w_base + ADDR'(r_cnt) * ADDR'(INST/8) : '0;
  // Line storage has no reset: only the valid bits gate its use.
  always_ff @(posedge clk) begin
    if (w_fill) begin
      r_data[{w_ridx, r_cnt}] <= bus.mem_rdata;
      if (w_last) r_tag[w_ridx] <= w_rtag;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_valid      <= '0;
      r_pc         <= '0;
      r_cnt        <= '0;
      r_word       <= '0;
      r_inst       <= '0;
      r_inst_valid <= 1'b0;
    end else begin
      r_inst_valid <= 1'b0;
      if (bus.flush) begin
        r_valid <= '0;
        r_state <= IDLE;
      end else if (r_state == REFILL) begin
        if (bus.mem_ack) begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == w_roff) r_word <= bus.mem_rdata;
          // Requested word may be the one arriving right now: bypass it.
          if (w_last) begin
            r_valid[w_ridx] <= 1'b1;
            r_inst          <= r_cnt == w_roff ? bus.mem_rdata : r_word;
            r_inst_valid    <= 1'b1;
            r_state         <= RESP;
          end
        end
      end else begin
        r_state <= IDLE;
        if (bus.fetch_req) begin
          if (w_hit) begin
            r_inst       <= r_data[{w_idx, w_off}];
            r_inst_valid <= 1'b1;
          end else begin
            r_state <= REFILL;
            r_pc    <= bus.fetch_pc;
            r_cnt   <= '0;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_icache_resp.sv
// tb_icache_resp: scoreboard bench with a word[a]=a memory model and a vector table of fetches
module tb_icache_resp;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  icache_resp_if #(.ADDR(32), .INST(32)) bus();
  icache_resp #(.ADDR(32), .INST(32), .LINE_WORDS(4), .SETS(64)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  typedef struct {
    logic [31:0] pc;
    logic [31:0] exp_inst;
    bit          miss;
  } vec_t;
  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int reqcyc = 0;
  int delay = 0;
  int wcnt = 0;
  logic [31:0] q[$];
  logic [31:0] acked[$];
  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    if (bus.mem_req === 1'b1) begin
      if (wcnt >= delay) begin
        bus.mem_ack = 1'b1;
        bus.mem_rdata = bus.mem_addr;
        acked.push_back(bus.mem_addr);
        wcnt = 0;
      end else begin
        bus.mem_ack = 1'b0;
        wcnt++;
      end
    end else begin
      bus.mem_ack = 1'b0;
      wcnt = 0;
    end
    @(posedge clk);
    #1;
    if (bus.mem_req === 1'b1) reqcyc++;
    if (bus.inst_valid === 1'b1) begin
      pulses++;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_inst_valid: got inst %h with no request pending", bus.inst);
      end else chk("inst", bus.inst, q.pop_front());
    end
  endtask

  task automatic issue(input logic [31:0] pc, input logic [31:0] exp, input bit push);
    bus.fetch_pc = pc;
    bus.fetch_req = 1'b1;
    chk("busy_at_req", {31'b0, bus.ic_busy}, 32'd0);
    if (push) q.push_back(exp);
    cyc();
    bus.fetch_req = 1'b0;
  endtask

  task automatic run(input logic [31:0] pc, input logic [31:0] exp, output int lat);
    int p0;
    p0 = pulses;
    issue(pc, exp, 1'b1);
    lat = 1;
    while (pulses == p0 && lat < 200) begin
      cyc();
      lat++;
    end
    chk("resp_seen", pulses - p0, 32'd1);
  endtask

  initial begin
    int lat, a0, p0, r0, n;
    vecs[0] = '{32'h0000_0100, 32'h0000_0100, 1'b0};
    vecs[1] = '{32'h0000_010E, 32'h0000_010C, 1'b0};
    vecs[2] = '{32'h0000_0500, 32'h0000_0500, 1'b1};
    vecs[3] = '{32'h0000_0508, 32'h0000_0508, 1'b0};
    vecs[4] = '{32'h0000_0104, 32'h0000_0104, 1'b1};
    vecs[5] = '{32'h0000_050C, 32'h0000_050C, 1'b1};
    vecs[6] = '{32'hFFFF_FFF8, 32'hFFFF_FFF8, 1'b1};
    vecs[7] = '{32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0};
    vecs[8] = '{32'h0000_0000, 32'h0000_0000, 1'b1};
    bus.fetch_req = 1'b0;
    bus.fetch_pc = '0;
    bus.flush = 1'b0;
    bus.mem_ack = 1'b0;
    bus.mem_rdata = '0;
    #12;
    chk("rst_busy", {31'b0, bus.ic_busy}, 32'd0);
    chk("rst_valid", {31'b0, bus.inst_valid}, 32'd0);
    chk("rst_inst", bus.inst, 32'd0);
    chk("rst_mreq", {31'b0, bus.mem_req}, 32'd0);
    chk("rst_maddr", bus.mem_addr, 32'd0);
    reset = 1'b0;
    cyc();
    // first fill: four ascending words, then response with ic_busy low
    a0 = acked.size();
    run(32'h100, 32'h100, lat);
    chk("fill_words", acked.size() - a0, 32'd4);
    if (acked.size() - a0 == 4)
      for (int i = 0; i < 4; i++) chk("fill_addr", acked[a0+i], 32'h100 + 32'(4*i));
    chk("busy_resp", {31'b0, bus.ic_busy}, 32'd0);
    // back-to-back hits at one instruction per cycle
    r0 = reqcyc;
    bus.fetch_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.fetch_pc = 32'h104 + 32'(4*i);
      q.push_back(32'h104 + 32'(4*i));
      chk("b2b_busy", {31'b0, bus.ic_busy}, 32'd0);
      cyc();
      chk("b2b_valid", {31'b0, bus.inst_valid}, 32'd1);
    end
    bus.fetch_req = 1'b0;
    cyc();
    chk("b2b_pulse_end", {31'b0, bus.inst_valid}, 32'd0);
    chk("b2b_no_mreq", reqcyc - r0, 32'd0);
    for (int i = 0; i < 9; i++) begin
      a0 = acked.size();
      run(vecs[i].pc, vecs[i].exp_inst, lat);
      if (vecs[i].miss) begin
        chk("miss_words", acked.size() - a0, 32'd4);
        if (acked.size() - a0 == 4) begin
          chk("miss_first", acked[a0], {vecs[i].pc[31:4], 4'h0});
          chk("miss_last", acked[a0+3], {vecs[i].pc[31:4], 4'hC});
        end
        chk("miss_busy_resp", {31'b0, bus.ic_busy}, 32'd0);
      end else begin
        chk("hit_latency", lat, 32'd1);
        chk("hit_nomem", acked.size() - a0, 32'd0);
      end
    end
    // slow memory: requests during refill are dropped, one pulse only
    delay = 5;
    a0 = acked.size();
    p0 = pulses;
    issue(32'h200, 32'h200, 1'b1);
    for (int i = 0; i < 15; i++) begin
      bus.fetch_req = 1'b1;
      bus.fetch_pc = 32'h104;
      chk("busy_refill", {31'b0, bus.ic_busy}, 32'd1);
      cyc();
    end
    bus.fetch_req = 1'b0;
    n = 0;
    while (pulses == p0 && n < 100) begin
      if (bus.mem_req === 1'b1) chk("busy_while_mreq", {31'b0, bus.ic_busy}, 32'd1);
      cyc();
      n++;
    end
    repeat (3) cyc();
    chk("slow_one_pulse", pulses - p0, 32'd1);
    chk("slow_words", acked.size() - a0, 32'd4);
    delay = 0;
    // flush after the second ack aborts the refill
    a0 = acked.size();
    issue(32'h300, 32'h300, 1'b0);
    n = 0;
    while (acked.size() - a0 < 2 && n < 20) begin
      cyc();
      n++;
    end
    p0 = pulses;
    bus.flush = 1'b1;
    chk("busy_flush", {31'b0, bus.ic_busy}, 32'd1);
    cyc();
    bus.flush = 1'b0;
    chk("mreq_after_flush", {31'b0, bus.mem_req}, 32'd0);
    repeat (5) cyc();
    chk("no_valid_flush", pulses - p0, 32'd0);
    a0 = acked.size();
    run(32'h300, 32'h300, lat);
    chk("refetch_words", acked.size() - a0, 32'd4);
    if (acked.size() - a0 == 4) chk("refetch_first", acked[a0], 32'h300);
    a0 = acked.size();
    run(32'h108, 32'h108, lat);
    chk("flush_invalidates", acked.size() - a0, 32'd4);
    // reset in the middle of a refill
    issue(32'h700, 32'h700, 1'b0);
    cyc();
    #2;
    reset = 1'b1;
    bus.mem_ack = 1'b0;
    #1;
    chk("rstmid_mreq", {31'b0, bus.mem_req}, 32'd0);
    chk("rstmid_maddr", bus.mem_addr, 32'd0);
    chk("rstmid_busy", {31'b0, bus.ic_busy}, 32'd0);
    chk("rstmid_valid", {31'b0, bus.inst_valid}, 32'd0);
    chk("rstmid_inst", bus.inst, 32'd0);
    @(posedge clk);
    #1;
    chk("rstmid_mreq_held", {31'b0, bus.mem_req}, 32'd0);
    #2;
    reset = 1'b0;
    wcnt = 0;
    a0 = acked.size();
    run(32'h304, 32'h304, lat);
    chk("miss_after_reset", acked.size() - a0, 32'd4);
    repeat (3) cyc();
    chk("queue_empty", q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, required finish before 200000");
    $fatal(1, "timeout");
  end
endmodule
